// File: rtl/wr_bram_pkg.sv
// Shared types and helpers for the FIFO-to-BRAM write controller.
//   state_e         : controller state encoding (3 bits)
//   CH_IMAGE/SECRET : BRAM channel indices
//   lane_mask_to_be : expand a per-lane valid mask into per-byte write enables
package wr_bram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int unsigned CH_IMAGE  = 0;
    localparam int unsigned CH_SECRET = 1;

    // Upper bounds for the generic mask expander (lanes per word, bytes per lane).
    localparam int unsigned MAX_LANES = 32;
    localparam int unsigned MAX_BPL   = 8;
    localparam int unsigned MAX_BYTES = MAX_LANES * MAX_BPL;

    // Each set lane bit enables bpl consecutive bytes, lane 0 in the LSBs.
    function automatic logic [MAX_BYTES-1:0] lane_mask_to_be(
        input logic [MAX_LANES-1:0] mask,
        input int unsigned          bpl
    );
        logic [MAX_BYTES-1:0] be;
        be = '0;
        for (int l = 0; l < int'(MAX_LANES); l++) begin
            for (int k = 0; k < int'(MAX_BPL); k++) begin
                if (k < int'(bpl)) begin
                    be[l * int'(bpl) + k] = mask[l];
                end
            end
        end
        return be;
    endfunction

endpackage

// File: rtl/lane_packer.sv
// Little-endian lane packer: collects FF_WIDTH entries into one LANES-wide word.
//   clear_i : empty the word, mask and lane pointer (wins over load_i)
//   load_i  : write data_i into the current lane, mark it valid, advance pointer
//   word_o  : packed word, unfilled lanes read as zero
//   mask_o  : one bit per filled lane
//   last_o  : pointer is on the final lane of the word
module lane_packer #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned FF_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_i,
    input  logic                      load_i,
    input  logic [FF_WIDTH-1:0]       data_i,
    output logic [LANES*FF_WIDTH-1:0] word_o,
    output logic [LANES-1:0]          mask_o,
    output logic                      last_o
);

    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES*FF_WIDTH-1:0] word_q, word_d;
    logic [LANES-1:0]          mask_q, mask_d;
    logic [LANE_W-1:0]         lane_q, lane_d;

    assign last_o = (lane_q == LANE_W'(LANES - 1));
    assign word_o = word_q;
    assign mask_o = mask_q;

    // Next-state for word, mask and pointer.
    always_comb begin
        word_d = word_q;
        mask_d = mask_q;
        lane_d = lane_q;
        if (clear_i) begin
            word_d = '0;
            mask_d = '0;
            lane_d = '0;
        end else if (load_i) begin
            for (int l = 0; l < int'(LANES); l++) begin
                if (lane_q == LANE_W'(l)) begin
                    word_d[l*FF_WIDTH +: FF_WIDTH] = data_i;
                    mask_d[l]                      = 1'b1;
                end
            end
            lane_d = last_o ? '0 : lane_q + LANE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            mask_q <= '0;
            lane_q <= '0;
        end else begin
            word_q <= word_d;
            mask_q <= mask_d;
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/ctrl_wr_bram_pack.sv
// FIFO-to-BRAM write controller: drains data_size FIFO entries, packs them
// little-endian into DATA_WIDTH words and writes each word once to the BRAM
// channel chosen at start, from base_addr upward; a trailing partial word is
// written with masked byte enables.
//   start/ch_sel/base_addr/data_size : command, latched in IDLE
//   busy/finish/err                  : status (err = channel out of range, sticky)
//   ff_empty/ff_rd_data/ff_rden      : show-ahead FIFO; ff_rd_data is taken at
//                                      the end of the cycle ff_rden is high
//   bram_clk/bram_wrdata/bram_addr/bram_we : shared BRAM write port, per-channel we
module ctrl_wr_bram_pack
    import wr_bram_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned ADDR_WIDTH = 32,
    parameter  int unsigned FF_WIDTH   = 8,
    parameter  int unsigned REG_WIDTH  = 32,
    parameter  int unsigned NUM_CH     = 2,
    localparam int unsigned LANES      = DATA_WIDTH / FF_WIDTH,
    localparam int unsigned NUM_BYTES  = DATA_WIDTH / 8,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [CH_W-1:0]             ch_sel,
    input  logic [REG_WIDTH-1:0]        base_addr,
    input  logic [REG_WIDTH-1:0]        data_size,
    output logic                        busy,
    output logic                        finish,
    output logic                        err,
    input  logic                        ff_empty,
    input  logic [FF_WIDTH-1:0]         ff_rd_data,
    output logic                        ff_rden,
    output logic                        bram_clk,
    output logic [DATA_WIDTH-1:0]       bram_wrdata,
    output logic [ADDR_WIDTH-1:0]       bram_addr,
    output logic [NUM_CH*NUM_BYTES-1:0] bram_we
);

    localparam int unsigned BPL   = NUM_BYTES / LANES;
    localparam int unsigned OFF_W = $clog2(NUM_BYTES);
    localparam int unsigned WE_W  = NUM_CH * NUM_BYTES;

    state_e                 state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [REG_WIDTH-1:0]   base_q, base_d;
    logic [REG_WIDTH-1:0]   size_q, size_d;
    logic [REG_WIDTH-1:0]   cnt_q, cnt_d;
    logic [REG_WIDTH-1:0]   widx_q, widx_d;
    logic                   busy_q, busy_d;
    logic                   finish_q, finish_d;
    logic                   err_q, err_d;
    logic                   rden_q, rden_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wrdata_q, wrdata_d;
    logic [WE_W-1:0]        we_q, we_d;

    logic                   pk_clear, pk_load, pk_last;
    logic [DATA_WIDTH-1:0]  pk_word;
    logic [LANES-1:0]       pk_mask;
    logic [NUM_BYTES-1:0]   word_be;
    logic [REG_WIDTH-1:0]   cnt_inc;
    logic [REG_WIDTH-1:0]   base_aligned;

    lane_packer #(
        .LANES    (LANES),
        .FF_WIDTH (FF_WIDTH)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (pk_clear),
        .load_i  (pk_load),
        .data_i  (ff_rd_data),
        .word_o  (pk_word),
        .mask_o  (pk_mask),
        .last_o  (pk_last)
    );

    assign word_be      = NUM_BYTES'(lane_mask_to_be(MAX_LANES'(pk_mask), BPL));
    assign cnt_inc      = cnt_q + REG_WIDTH'(1);
    assign base_aligned = (base_q >> OFF_W) << OFF_W;

    assign bram_clk    = clk;
    assign busy        = busy_q;
    assign finish      = finish_q;
    assign err         = err_q;
    assign ff_rden     = rden_q;
    assign bram_addr   = addr_q;
    assign bram_wrdata = wrdata_q;
    assign bram_we     = we_q;

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        base_d   = base_q;
        size_d   = size_q;
        cnt_d    = cnt_q;
        widx_d   = widx_q;
        busy_d   = busy_q;
        finish_d = finish_q;
        err_d    = err_q;
        rden_d   = 1'b0;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        we_d     = '0;
        pk_clear = 1'b0;
        pk_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ch_d     = ch_sel;
                    base_d   = base_addr;
                    size_d   = data_size;
                    cnt_d    = '0;
                    widx_d   = '0;
                    pk_clear = 1'b1;
                    err_d    = (32'(ch_sel) >= NUM_CH);
                    if (data_size == '0) begin
                        busy_d   = 1'b0;
                        finish_d = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        busy_d   = 1'b1;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (cnt_q == size_q) begin
                    busy_d   = 1'b0;
                    finish_d = 1'b1;
                    state_d  = ST_DONE;
                end else if (!ff_empty) begin
                    rden_d  = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                pk_load = 1'b1;
                cnt_d   = cnt_inc;
                state_d = (pk_last || cnt_inc == size_q) ? ST_WRITE : ST_REQ;
            end
            ST_WRITE: begin
                // Address arithmetic is ADDR_WIDTH wide so it wraps silently.
                addr_d   = ADDR_WIDTH'(base_aligned)
                         + ADDR_WIDTH'(widx_q) * ADDR_WIDTH'(NUM_BYTES);
                wrdata_d = pk_word;
                for (int c = 0; c < int'(NUM_CH); c++) begin
                    if (!err_q && ch_q == CH_W'(c)) begin
                        we_d[c*NUM_BYTES +: NUM_BYTES] = word_be;
                    end
                end
                widx_d   = widx_q + REG_WIDTH'(1);
                pk_clear = 1'b1;
                state_d  = ST_REQ;
            end
            ST_DONE: begin
                if (!start) begin
                    finish_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            base_q   <= '0;
            size_q   <= '0;
            cnt_q    <= '0;
            widx_q   <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            err_q    <= 1'b0;
            rden_q   <= 1'b0;
            addr_q   <= '0;
            wrdata_q <= '0;
            we_q     <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            base_q   <= base_d;
            size_q   <= size_d;
            cnt_q    <= cnt_d;
            widx_q   <= widx_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
            err_q    <= err_d;
            rden_q   <= rden_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            we_q     <= we_d;
        end
    end

endmodule
